// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared definitions for the CDB arbiter slice.
//   CDB_XLEN       default data / PC width
//   CDB_ROB_IDX_W  default ROB index width (64-entry ROB)
//   cdb_entry_t    one broadcast record {pc, rob_idx, data}
//   cdb_age()      wrap-aware distance of a ROB slot from the ROB head
// -----------------------------------------------------------------------------
package cdb_pkg;

  localparam int unsigned CDB_XLEN      = 32;
  localparam int unsigned CDB_ROB_IDX_W = 6;

  typedef struct packed {
    logic [CDB_XLEN-1:0]      pc;
    logic [CDB_ROB_IDX_W-1:0] rob_idx;
    logic [CDB_XLEN-1:0]      data;
  } cdb_entry_t;

  // (idx - head) mod 2^w: slots just behind the head wrap to the largest age.
  function automatic int unsigned cdb_age(input int unsigned idx,
                                          input int unsigned head,
                                          input int unsigned w);
    return (idx - head) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// -----------------------------------------------------------------------------
// cdb_rr_pick
// One selection stage of the CDB grant chain.
// Default build: round-robin pick of the first set bit of i_valid at or after
// i_start (wrapping). With CDB_AGE_PRIORITY_EN defined: pick the valid
// requester with the smallest ROB age relative to i_rob_head, ties to the
// lower index; i_start is then ignored.
// Ports:
//   i_valid     candidate mask (earlier stages' picks already removed)
//   i_start     round-robin start index
//   i_rob_idx   packed ROB slots per requester (age build only)
//   i_rob_head  oldest ROB slot (age build only)
//   o_onehot    one-hot pick
//   o_idx       index of the pick
//   o_found     a candidate was picked
// -----------------------------------------------------------------------------
module cdb_rr_pick
  import cdb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 6,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]   i_valid,
  input  logic [PW-1:0]  i_start,
`ifdef CDB_AGE_PRIORITY_EN
  input  logic [N*W-1:0] i_rob_idx,
  input  logic [W-1:0]   i_rob_head,
`endif
  output logic [N-1:0]   o_onehot,
  output logic [PW-1:0]  o_idx,
  output logic           o_found
);

`ifdef CDB_AGE_PRIORITY_EN

  logic w_unused_start;
  assign w_unused_start = ^i_start;

  // Linear min-age reduction; strict '<' keeps the lower index on ties.
  always_comb begin
    int unsigned age;
    int unsigned best;
    age      = 0;
    best     = 0;
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      age = cdb_age(32'(i_rob_idx[i*W +: W]), 32'(i_rob_head), W);
      if (i_valid[i] && (!o_found || age < best)) begin
        o_found = 1'b1;
        best    = age;
        o_idx   = PW'(i);
      end
    end
    if (o_found) o_onehot[o_idx] = 1'b1;
  end

`else

  always_comb begin
    int unsigned s;
    logic [PW-1:0] j;
    s        = 0;
    j        = '0;
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      s = 32'(i_start) + off;
      if (s >= N) s = s - N;
      j = PW'(s);
      if (!o_found && i_valid[j]) begin
        o_found     = 1'b1;
        o_onehot[j] = 1'b1;
        o_idx       = j;
      end
    end
  end

`endif

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Grants up to NUM_CDB of NUM_REQ completed execution-unit results per cycle
// and registers them onto the common data bus (ROB completion / wakeup).
// Optional macro: CDB_AGE_PRIORITY_EN selects oldest-first (ROB age) grants
// instead of round-robin.
// Ports:
//   clk, rstn            clock, async active-low reset
//   req_valid/pc/rob_idx/data  per-requester completed result
//   req_ready            combinational grant per requester
//   rob_head             oldest ROB slot (age build only)
//   cdb_stall            ROB back-pressure: no grants
//   flush                pipeline flush: no grants, pointer reset
//   cdb_valid/pc/rob_idx/data  registered broadcast, one cycle per result
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_CDB   = 2,
  parameter int unsigned XLEN      = CDB_XLEN,
  parameter int unsigned ROB_IDX_W = CDB_ROB_IDX_W
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*XLEN-1:0]        req_pc,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx,
  input  logic [NUM_REQ*XLEN-1:0]        req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [ROB_IDX_W-1:0]           rob_head,
  input  logic                           cdb_stall,
  input  logic                           flush,
  output logic [NUM_CDB-1:0]             cdb_valid,
  output logic [NUM_CDB*XLEN-1:0]        cdb_pc,
  output logic [NUM_CDB*ROB_IDX_W-1:0]   cdb_rob_idx,
  output logic [NUM_CDB*XLEN-1:0]        cdb_data
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]          r_rr_ptr;
  logic [PW-1:0]          w_rr_next;
  logic [PW-1:0]          w_last_idx;
  logic                   w_grant_en;

  logic [XLEN-1:0]        w_pc  [NUM_REQ];
  logic [ROB_IDX_W-1:0]   w_rob [NUM_REQ];
  logic [XLEN-1:0]        w_dat [NUM_REQ];

  logic [NUM_CDB-1:0][NUM_REQ-1:0] w_avail;
  logic [NUM_CDB-1:0][NUM_REQ-1:0] w_pick_oh;
  logic [NUM_CDB-1:0][PW-1:0]      w_pick_idx;
  logic [NUM_CDB-1:0]              w_pick_found;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_pc[g]  = req_pc[g*XLEN +: XLEN];
    assign w_rob[g] = req_rob_idx[g*ROB_IDX_W +: ROB_IDX_W];
    assign w_dat[g] = req_data[g*XLEN +: XLEN];
  end

  // Stage k sees only requesters not picked by stages 0..k-1, so the chain
  // yields the 1st, 2nd, ... candidate in scan (or age) order.
  for (genvar k = 0; k < NUM_CDB; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_avail[k] = req_valid;
    end else begin : g_next
      assign w_avail[k] = w_avail[k-1] & ~w_pick_oh[k-1];
    end

    cdb_rr_pick #(
      .N  (NUM_REQ),
      .W  (ROB_IDX_W),
      .PW (PW)
    ) u_pick (
      .i_valid    (w_avail[k]),
      .i_start    (r_rr_ptr),
`ifdef CDB_AGE_PRIORITY_EN
      .i_rob_idx  (req_rob_idx),
      .i_rob_head (rob_head),
`endif
      .o_onehot   (w_pick_oh[k]),
      .o_idx      (w_pick_idx[k]),
      .o_found    (w_pick_found[k])
    );
  end

  assign w_grant_en = rstn & ~flush & ~cdb_stall;

  always_comb begin
    req_ready = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      req_ready = req_ready | w_pick_oh[k];
    end
    if (!w_grant_en) req_ready = '0;
  end

  // Stages find candidates as a prefix, so the last found stage holds the
  // last granted requester.
  always_comb begin
    w_last_idx = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      if (w_pick_found[k]) w_last_idx = w_pick_idx[k];
    end
  end

`ifdef CDB_AGE_PRIORITY_EN
  logic w_unused_last;
  assign w_unused_last = ^w_last_idx;
  assign w_rr_next     = '0;
`else
  logic w_unused_head;
  assign w_unused_head = ^rob_head;
  assign w_rr_next     = (w_last_idx == PW'(NUM_REQ - 1)) ? '0 : w_last_idx + 1'b1;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cdb_valid   <= '0;
      cdb_pc      <= '0;
      cdb_rob_idx <= '0;
      cdb_data    <= '0;
      r_rr_ptr    <= '0;
    end else if (flush) begin
      cdb_valid <= '0;
      r_rr_ptr  <= '0;
    end else if (cdb_stall) begin
      cdb_valid <= '0;
    end else begin
      cdb_valid <= w_pick_found;
      for (int unsigned k = 0; k < NUM_CDB; k++) begin
        if (w_pick_found[k]) begin
          cdb_pc[k*XLEN +: XLEN]                <= w_pc[w_pick_idx[k]];
          cdb_rob_idx[k*ROB_IDX_W +: ROB_IDX_W] <= w_rob[w_pick_idx[k]];
          cdb_data[k*XLEN +: XLEN]              <= w_dat[w_pick_idx[k]];
        end
      end
      if (|w_pick_found) r_rr_ptr <= w_rr_next;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        for (int unsigned j = i + 1; j < NUM_REQ; j++) begin
          assert (!(req_valid[i] && req_valid[j] && (w_rob[i] == w_rob[j])))
            else $error("cdb_arbiter: duplicate req_rob_idx on requesters %0d and %0d", i, j);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  logic         clk;
  logic         rstn;
  logic [3:0]   req_valid;
  logic [127:0] req_pc;
  logic [23:0]  req_rob_idx;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [5:0]   rob_head;
  logic         cdb_stall;
  logic         flush;
  logic [1:0]   cdb_valid;
  logic [63:0]  cdb_pc;
  logic [11:0]  cdb_rob_idx;
  logic [63:0]  cdb_data;

  int n_checks = 0;
  int n_errors = 0;

  cdb_arbiter #(
    .NUM_REQ   (4),
    .NUM_CDB   (2),
    .XLEN      (32),
    .ROB_IDX_W (6)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_pc      (req_pc),
    .req_rob_idx (req_rob_idx),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rob_head    (rob_head),
    .cdb_stall   (cdb_stall),
    .flush       (flush),
    .cdb_valid   (cdb_valid),
    .cdb_pc      (cdb_pc),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_data    (cdb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic [31:0] pc,
                         input logic [5:0] rob, input logic [31:0] data);
    req_valid[i]          = 1'b1;
    req_pc[i*32 +: 32]    = pc;
    req_rob_idx[i*6 +: 6] = rob;
    req_data[i*32 +: 32]  = data;
  endtask

  task automatic test_reset();
    rstn = 1'b1; req_valid = '0; req_pc = '0; req_rob_idx = '0; req_data = '0;
    rob_head = '0; cdb_stall = 1'b0; flush = 1'b0;
    #2 rstn = 1'b0;
    for (int unsigned i = 0; i < 4; i++) set_req(i, 32'h100 + 32'(4*i), 6'(10+i), 32'hA0 + 32'(i));
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    n_checks++; if (cdb_valid !== 2'b00) begin n_errors++; $display("FAIL rst_valid: got %b want 00", cdb_valid); end
    n_checks++; if (dut.r_rr_ptr !== 2'd0) begin n_errors++; $display("FAIL rst_ptr: got %0d want 0", dut.r_rr_ptr); end
    @(negedge clk) rstn = 1'b1;
    tick();
    n_checks++; if (cdb_valid !== 2'b11) begin n_errors++; $display("FAIL pre_rst_bcast: got %b want 11", cdb_valid); end
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (cdb_valid !== 2'b00) begin n_errors++; $display("FAIL async_rst_valid: got %b want 00", cdb_valid); end
    n_checks++; if (cdb_pc !== 64'd0) begin n_errors++; $display("FAIL async_rst_pc: got %h want 0", cdb_pc); end
    n_checks++; if (cdb_rob_idx !== 12'd0) begin n_errors++; $display("FAIL async_rst_rob: got %h want 0", cdb_rob_idx); end
    n_checks++; if (cdb_data !== 64'd0) begin n_errors++; $display("FAIL async_rst_data: got %h want 0", cdb_data); end
    n_checks++; if (dut.r_rr_ptr !== 2'd0) begin n_errors++; $display("FAIL async_rst_ptr: got %0d want 0", dut.r_rr_ptr); end
    n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL async_rst_ready: got %b want 0000", req_ready); end
    @(negedge clk) begin rstn = 1'b1; req_valid = '0; end
    tick();
  endtask

  task automatic test_all_four();
    for (int unsigned i = 0; i < 4; i++) set_req(i, 32'h100 + 32'(4*i), 6'(10+i), 32'hA0 + 32'(i));
    #1;
    n_checks++; if (req_ready !== 4'b0011) begin n_errors++; $display("FAIL all4_ready1: got %b want 0011", req_ready); end
    tick();
    n_checks++; if (cdb_valid !== 2'b11) begin n_errors++; $display("FAIL all4_valid1: got %b want 11", cdb_valid); end
    n_checks++; if (cdb_pc !== {32'h104, 32'h100}) begin n_errors++; $display("FAIL all4_pc1: got %h want 0000010400000100", cdb_pc); end
    n_checks++; if (cdb_rob_idx !== {6'd11, 6'd10}) begin n_errors++; $display("FAIL all4_rob1: got %h want %h", cdb_rob_idx, {6'd11, 6'd10}); end
    n_checks++; if (dut.r_rr_ptr !== 2'd2) begin n_errors++; $display("FAIL all4_ptr1: got %0d want 2", dut.r_rr_ptr); end
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b1100) begin n_errors++; $display("FAIL all4_ready2: got %b want 1100", req_ready); end
    tick();
    n_checks++; if (cdb_valid !== 2'b11) begin n_errors++; $display("FAIL all4_valid2: got %b want 11", cdb_valid); end
    n_checks++; if (cdb_pc !== {32'h10C, 32'h108}) begin n_errors++; $display("FAIL all4_pc2: got %h want 0000010c00000108", cdb_pc); end
    n_checks++; if (cdb_data !== {32'hA3, 32'hA2}) begin n_errors++; $display("FAIL all4_data2: got %h want 000000a3000000a2", cdb_data); end
    n_checks++; if (dut.r_rr_ptr !== 2'd0) begin n_errors++; $display("FAIL all4_ptr2: got %0d want 0", dut.r_rr_ptr); end
    req_valid = '0;
    tick();
    n_checks++; if (cdb_valid !== 2'b00) begin n_errors++; $display("FAIL all4_one_cycle: got %b want 00", cdb_valid); end
    n_checks++; if (cdb_pc !== {32'h10C, 32'h108}) begin n_errors++; $display("FAIL all4_stale_hold: got %h want 0000010c00000108", cdb_pc); end
  endtask

  task automatic test_single();
    set_req(3, 32'h200, 6'd5, 32'hDEADBEEF);
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL single_ready: got %b want 1000", req_ready); end
    tick();
    n_checks++; if (cdb_valid !== 2'b01) begin n_errors++; $display("FAIL single_valid: got %b want 01", cdb_valid); end
    n_checks++; if (cdb_rob_idx[5:0] !== 6'd5) begin n_errors++; $display("FAIL single_rob: got %0d want 5", cdb_rob_idx[5:0]); end
    n_checks++; if (cdb_data[31:0] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_data: got %h want deadbeef", cdb_data[31:0]); end
    n_checks++; if (dut.r_rr_ptr !== 2'd0) begin n_errors++; $display("FAIL single_ptr: got %0d want 0", dut.r_rr_ptr); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_stall();
    cdb_stall = 1'b1;
    set_req(0, 32'h300, 6'd20, 32'h1);
    for (int n = 0; n < 3; n++) begin
      #1;
      n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL stall_ready[%0d]: got %b want 0000", n, req_ready); end
      tick();
      n_checks++; if (cdb_valid !== 2'b00) begin n_errors++; $display("FAIL stall_valid[%0d]: got %b want 00", n, cdb_valid); end
      n_checks++; if (dut.r_rr_ptr !== 2'd0) begin n_errors++; $display("FAIL stall_ptr[%0d]: got %0d want 0", n, dut.r_rr_ptr); end
    end
    cdb_stall = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL unstall_ready: got %b want 0001", req_ready); end
    tick();
    n_checks++; if (cdb_valid !== 2'b01) begin n_errors++; $display("FAIL unstall_valid: got %b want 01", cdb_valid); end
    n_checks++; if (cdb_pc[31:0] !== 32'h300) begin n_errors++; $display("FAIL unstall_pc: got %h want 00000300", cdb_pc[31:0]); end
    n_checks++; if (dut.r_rr_ptr !== 2'd1) begin n_errors++; $display("FAIL unstall_ptr: got %0d want 1", dut.r_rr_ptr); end
    req_valid = '0;
  endtask

  task automatic test_flush();
    set_req(1, 32'h310, 6'd21, 32'h2);
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL fl_setup_ready: got %b want 0010", req_ready); end
    tick();
    n_checks++; if (dut.r_rr_ptr !== 2'd2) begin n_errors++; $display("FAIL fl_setup_ptr: got %0d want 2", dut.r_rr_ptr); end
    req_valid = '0;
    set_req(0, 32'h400, 6'd30, 32'h30);
    set_req(1, 32'h404, 6'd31, 32'h31);
    set_req(2, 32'h408, 6'd32, 32'h32);
    flush = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL flush_ready: got %b want 0000", req_ready); end
    tick();
    n_checks++; if (cdb_valid !== 2'b00) begin n_errors++; $display("FAIL flush_valid: got %b want 00", cdb_valid); end
    n_checks++; if (dut.r_rr_ptr !== 2'd0) begin n_errors++; $display("FAIL flush_ptr: got %0d want 0", dut.r_rr_ptr); end
    flush = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0011) begin n_errors++; $display("FAIL postflush_ready: got %b want 0011", req_ready); end
    tick();
    n_checks++; if (cdb_pc !== {32'h404, 32'h400}) begin n_errors++; $display("FAIL postflush_pc: got %h want 0000040400000400", cdb_pc); end
    n_checks++; if (dut.r_rr_ptr !== 2'd2) begin n_errors++; $display("FAIL postflush_ptr: got %0d want 2", dut.r_rr_ptr); end
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    flush = 1'b1; cdb_stall = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL flstall_ready: got %b want 0000", req_ready); end
    tick();
    n_checks++; if (dut.r_rr_ptr !== 2'd0) begin n_errors++; $display("FAIL flstall_ptr: got %0d want 0", dut.r_rr_ptr); end
    flush = 1'b0; cdb_stall = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL req2_ready: got %b want 0100", req_ready); end
    tick();
    n_checks++; if (cdb_valid !== 2'b01 || cdb_pc[31:0] !== 32'h408) begin n_errors++; $display("FAIL req2_bcast: got valid %b pc %h want 01 00000408", cdb_valid, cdb_pc[31:0]); end
    n_checks++; if (dut.r_rr_ptr !== 2'd3) begin n_errors++; $display("FAIL req2_ptr: got %0d want 3", dut.r_rr_ptr); end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    set_req(0, 32'h500, 6'd40, 32'h40);
    set_req(3, 32'h50C, 6'd43, 32'h43);
    #1;
    n_checks++; if (req_ready !== 4'b1001) begin n_errors++; $display("FAIL wrap_ready: got %b want 1001", req_ready); end
    tick();
    n_checks++; if (cdb_valid !== 2'b11) begin n_errors++; $display("FAIL wrap_valid: got %b want 11", cdb_valid); end
    n_checks++; if (cdb_pc !== {32'h500, 32'h50C}) begin n_errors++; $display("FAIL wrap_pc: got %h want 000005000000050c", cdb_pc); end
    n_checks++; if (dut.r_rr_ptr !== 2'd1) begin n_errors++; $display("FAIL wrap_ptr: got %0d want 1", dut.r_rr_ptr); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_age();
    rob_head = 6'd60;
    set_req(0, 32'h600, 6'd2,  32'h60);
    set_req(1, 32'h604, 6'd61, 32'h61);
    set_req(2, 32'h608, 6'd63, 32'h62);
    #1;
    n_checks++; if (req_ready !== 4'b0110) begin n_errors++; $display("FAIL age_ready1: got %b want 0110", req_ready); end
    tick();
    n_checks++; if (cdb_valid !== 2'b11) begin n_errors++; $display("FAIL age_valid1: got %b want 11", cdb_valid); end
    n_checks++; if (cdb_rob_idx !== {6'd63, 6'd61}) begin n_errors++; $display("FAIL age_rob1: got %h want %h", cdb_rob_idx, {6'd63, 6'd61}); end
    n_checks++; if (dut.r_rr_ptr !== 2'd0) begin n_errors++; $display("FAIL age_ptr: got %0d want 0", dut.r_rr_ptr); end
    req_valid[1] = 1'b0; req_valid[2] = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL age_ready2: got %b want 0001", req_ready); end
    tick();
    n_checks++; if (cdb_valid !== 2'b01 || cdb_rob_idx[5:0] !== 6'd2) begin n_errors++; $display("FAIL age_bcast2: got valid %b rob %0d want 01 2", cdb_valid, cdb_rob_idx[5:0]); end
    req_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
`ifdef CDB_AGE_PRIORITY_EN
    test_age();
`else
    test_all_four();
    test_single();
    test_stall();
    test_flush();
    test_wrap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
